led_pwm_filament_driver: RTL and testbench

Converts the 8-bit-per-filament palette values into registered PWM drive signals for the color LED filaments (red/green/blue) and the basic LEDs. It sits directly downstream of the palette updater and directly upstream of the board LED pins. A shared prescaler and step counter set the period. Duty values are captured at period boundaries so that a palette change never produces a truncated or glitched pulse.

---
 rtl/led_pwm_filament_driver_if.sv | 36 +++
 rtl/led_pwm_filament_driver.sv | 101 ++++++++++
 tb/tb_led_pwm_filament_driver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/led_pwm_filament_driver_if.sv
// Purpose : Bundles the palette duty values and the LED drive lines of
//           led_pwm_filament_driver into one port.
// Signals : i_color_led_{red,green,blue}_value  8 bits per color LED
//           i_basic_led_lumin_value             8 bits per basic LED
//           o_color_led_{red,green,blue}        1 bit per color LED
//           o_basic_led                         1 bit per basic LED
//           o_period_start                      1-clock pulse per PWM period
// Modports: master = palette/board side, slave = PWM driver.
interface led_pwm_filament_driver_if #(
    parameter int unsigned parm_color_led_count = 4,
    parameter int unsigned parm_basic_led_count = 4
);
    logic [8*parm_color_led_count-1:0] i_color_led_red_value;
    logic [8*parm_color_led_count-1:0] i_color_led_green_value;
    logic [8*parm_color_led_count-1:0] i_color_led_blue_value;
    logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value;
    logic [parm_color_led_count-1:0]   o_color_led_red;
    logic [parm_color_led_count-1:0]   o_color_led_green;
    logic [parm_color_led_count-1:0]   o_color_led_blue;
    logic [parm_basic_led_count-1:0]   o_basic_led;
    logic                              o_period_start;

    modport master (
        output i_color_led_red_value, i_color_led_green_value,
               i_color_led_blue_value, i_basic_led_lumin_value,
        input  o_color_led_red, o_color_led_green, o_color_led_blue,
               o_basic_led, o_period_start
    );

    modport slave (
        input  i_color_led_red_value, i_color_led_green_value,
               i_color_led_blue_value, i_basic_led_lumin_value,
        output o_color_led_red, o_color_led_green, o_color_led_blue,
               o_basic_led, o_period_start
    );
endinterface

// File: rtl/led_pwm_filament_driver.sv
// Purpose : Registered PWM drive for RGB LED filaments and basic LEDs.
//           A shared prescaler and 0..254 step counter define a period of
//           255*parm_pwm_step_clocks clocks; every output is
//           (step < duty), registered, so all filaments rise together at
//           the period start.
// Ports   : i_clk    system clock (rising edge)
//           i_arstn  asynchronous active-low reset
//           i_leds   led_pwm_filament_driver_if.slave (duties in, drives out)
// Config  : LED_PWM_LATCH_AT_PERIOD_EN defined  -> duties captured only at the
//           period boundary (whole pulses). Undefined -> duties follow the
//           inputs every clock.
module led_pwm_filament_driver #(
    parameter int unsigned parm_color_led_count = 4,
    parameter int unsigned parm_basic_led_count = 4,
    parameter int unsigned parm_pwm_step_clocks = 16
) (
    input  logic                            i_clk,
    input  logic                            i_arstn,
    led_pwm_filament_driver_if.slave        i_leds
);
    localparam int unsigned LP_NC = parm_color_led_count;
    localparam int unsigned LP_NB = parm_basic_led_count;
    localparam int unsigned LP_NF = 3 * LP_NC + LP_NB;
    localparam logic [15:0] LP_PRESCALE_LAST = 16'(parm_pwm_step_clocks - 1);
    localparam logic [7:0]  LP_STEP_LAST     = 8'd254;

    logic [15:0]          r_prescale;
    logic [7:0]           r_step;
    logic [LP_NF-1:0]     r_drive;
    logic                 r_period_start;
    logic                 w_tick;
    logic                 w_boundary;
    logic [8*LP_NF-1:0]   w_duty_in;
    logic [8*LP_NF-1:0]   w_duty_cmp;
    logic [LP_NF-1:0]     w_drive_next;

    assign w_tick     = (r_prescale == LP_PRESCALE_LAST);
    assign w_boundary = (r_prescale == 16'd0) && (r_step == 8'd0);

    // Flattened duty vector: red, green, blue, basic from the LSB up.
    assign w_duty_in = {i_leds.i_basic_led_lumin_value,
                        i_leds.i_color_led_blue_value,
                        i_leds.i_color_led_green_value,
                        i_leds.i_color_led_red_value};

`ifdef LED_PWM_LATCH_AT_PERIOD_EN
    logic [8*LP_NF-1:0] r_duty;

    // Duties held for the whole period; captured only at the boundary.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_duty <= '0;
        end else if (w_boundary) begin
            r_duty <= w_duty_in;
        end
    end

    // The boundary compare must use the fresh input, not the old register.
    assign w_duty_cmp = w_boundary ? w_duty_in : r_duty;
`else
    assign w_duty_cmp = w_duty_in;
`endif

    // Per-filament duty compare.
    always_comb begin
        w_drive_next = '0;
        for (int unsigned f = 0; f < LP_NF; f++) begin
            w_drive_next[f] = (r_step < w_duty_cmp[8*f +: 8]);
        end
    end

    // Prescaler and step counter.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_prescale <= '0;
            r_step     <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
            r_step     <= (r_step == LP_STEP_LAST) ? 8'd0 : r_step + 8'd1;
        end else begin
            r_prescale <= r_prescale + 16'd1;
        end
    end

    // Output registers; the boundary cycle shows up one clock later.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_drive        <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_drive        <= w_drive_next;
            r_period_start <= w_boundary;
        end
    end

    assign i_leds.o_color_led_red   = r_drive[0 +: LP_NC];
    assign i_leds.o_color_led_green = r_drive[LP_NC +: LP_NC];
    assign i_leds.o_color_led_blue  = r_drive[2*LP_NC +: LP_NC];
    assign i_leds.o_basic_led       = r_drive[3*LP_NC +: LP_NB];
    assign i_leds.o_period_start    = r_period_start;
endmodule

// File: tb/tb_led_pwm_filament_driver.sv
// Purpose : Directed self-checking bench for led_pwm_filament_driver.
//           DUT A: step_clocks=2 (510-clock period); DUT B: step_clocks=1.
module tb_led_pwm_filament_driver;
`ifdef LED_PWM_LATCH_AT_PERIOD_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic clk;
    logic arstn;

    led_pwm_filament_driver_if #(.parm_color_led_count(4), .parm_basic_led_count(4)) a_if ();
    led_pwm_filament_driver_if #(.parm_color_led_count(4), .parm_basic_led_count(4)) b_if ();

    led_pwm_filament_driver #(
        .parm_color_led_count(4), .parm_basic_led_count(4), .parm_pwm_step_clocks(2)
    ) u_dut_a (
        .i_clk(clk), .i_arstn(arstn), .i_leds(a_if)
    );

    led_pwm_filament_driver #(
        .parm_color_led_count(4), .parm_basic_led_count(4), .parm_pwm_step_clocks(1)
    ) u_dut_b (
        .i_clk(clk), .i_arstn(arstn), .i_leds(b_if)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int k;
    int a_ps_cnt, a_ps_misplaced, red0_low, basic1_low;
    int green2_high, green2_shape_err, blue3_high, others_high;
    int b_ps_cnt, b_red0_high, b_align_err;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        a_ps_cnt = 0; a_ps_misplaced = 0; red0_low = 0; basic1_low = 0;
        green2_high = 0; green2_shape_err = 0; blue3_high = 0; others_high = 0;
        b_ps_cnt = 0; b_red0_high = 0; b_align_err = 0;
    endtask

    task automatic sample();
        int ph;
        logic [3:0] others_v;
        ph = (k - 1) % 510;
        if (a_if.o_period_start) begin
            a_ps_cnt++;
            if (ph != 0) a_ps_misplaced++;
        end
        if (!a_if.o_color_led_red[0]) red0_low++;
        if (!a_if.o_basic_led[1]) basic1_low++;
        if (a_if.o_color_led_green[2]) green2_high++;
        if (a_if.o_color_led_green[2] != (ph < 256)) green2_shape_err++;
        if (a_if.o_color_led_blue[3]) blue3_high++;
        others_v = (a_if.o_color_led_red & 4'b1110) | (a_if.o_color_led_green & 4'b1011) |
                   (a_if.o_color_led_blue & 4'b0111) | (a_if.o_basic_led & 4'b1101);
        if (others_v != 4'b0) others_high++;
        if (b_if.o_period_start) b_ps_cnt++;
        if (b_if.o_color_led_red[0]) b_red0_high++;
        if (b_if.o_color_led_red[0] != b_if.o_period_start) b_align_err++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
            sample();
        end
    endtask

    function automatic int a_all_outputs();
        return int'({a_if.o_color_led_red, a_if.o_color_led_green, a_if.o_color_led_blue,
                     a_if.o_basic_led, a_if.o_period_start});
    endfunction

    initial begin
        clk = 1'b0;
        arstn = 1'b0;
        n_checks = 0;
        n_errors = 0;
        k = 0;
        a_if.i_color_led_red_value   = 32'h0000_00FF;
        a_if.i_color_led_green_value = 32'h0080_0000;
        a_if.i_color_led_blue_value  = 32'h1000_0000;
        a_if.i_basic_led_lumin_value = 32'h0000_FF00;
        b_if.i_color_led_red_value   = 32'h0000_0001;
        b_if.i_color_led_green_value = 32'h0;
        b_if.i_color_led_blue_value  = 32'h0;
        b_if.i_basic_led_lumin_value = 32'h0;

        #2;
        check_eq("reset_a_outputs", a_all_outputs(), 0);
        check_eq("reset_b_ps", int'(b_if.o_period_start), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;

        // Three full periods with static duties.
        clear_stats();
        run_cycles(1);
        check_eq("b0p1_period_start", int'(a_if.o_period_start), 1);
        check_eq("b0p1_red0", int'(a_if.o_color_led_red[0]), 1);
        check_eq("b0p1_basic1", int'(a_if.o_basic_led[1]), 1);
        check_eq("b0p1_green2", int'(a_if.o_color_led_green[2]), 1);
        run_cycles(1529);
        check_eq("p123_ps_count", a_ps_cnt, 3);
        check_eq("p123_ps_misplaced", a_ps_misplaced, 0);
        check_eq("p123_red0_low", red0_low, 0);
        check_eq("p123_basic1_low", basic1_low, 0);
        check_eq("p123_green2_high", green2_high, 768);
        check_eq("p123_green2_shape", green2_shape_err, 0);
        check_eq("p123_blue3_high", blue3_high, 96);
        check_eq("p123_zero_duty_high", others_high, 0);
        check_eq("b_ps_count", b_ps_cnt, 6);
        check_eq("b_red0_high", b_red0_high, 6);
        check_eq("b_red0_align", b_align_err, 0);

        // Period 4: blue[3] 0x10 -> 0xF0 while the step counter is at 100.
        clear_stats();
        run_cycles(201);
        a_if.i_color_led_blue_value = 32'hF000_0000;
        run_cycles(1);
        check_eq("blue3_after_change", int'(a_if.o_color_led_blue[3]), LATCH ? 0 : 1);
        run_cycles(308);
        check_eq("p4_blue3_high", blue3_high, LATCH ? 32 : 311);
        check_eq("p4_ps_count", a_ps_cnt, 1);

        // Period 5: new duty applies to the whole period.
        clear_stats();
        run_cycles(510);
        check_eq("p5_blue3_high", blue3_high, 480);
        check_eq("p5_green2_high", green2_high, 256);

        // Period 6: reset at step 60 for 3 clocks.
        clear_stats();
        run_cycles(120);
        check_eq("pre_reset_green2", int'(a_if.o_color_led_green[2]), 1);
        arstn = 1'b0;
        #1;
        check_eq("async_reset_outputs", a_all_outputs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("held_reset_outputs", a_all_outputs(), 0);
        end
        @(negedge clk);
        arstn = 1'b1;
        k = 0;
        clear_stats();
        run_cycles(1);
        check_eq("post_reset_ps", int'(a_if.o_period_start), 1);
        check_eq("post_reset_red0", int'(a_if.o_color_led_red[0]), 1);
        run_cycles(1);
        check_eq("post_reset_ps_width", int'(a_if.o_period_start), 0);
        run_cycles(508);
        check_eq("post_reset_ps_count", a_ps_cnt, 1);
        check_eq("post_reset_green2_shape", green2_shape_err, 0);
        check_eq("post_reset_green2_high", green2_high, 256);
        check_eq("post_reset_red0_low", red0_low, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
